bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (double-dabble, one bit per cycle) that drives the 24-bit six-digit bus feeding the board's hex_7seg digit decoders.
- Sits between a binary source (PIO, counter or measurement logic) and the HEX0..HEX5 decoders, so decimal values display without software conversion.
- Valid/ready input handshake; one-cycle done pulse on output; result register holds the last value between conversions.

---
 rtl/bin2bcd_pkg.sv | 23 ++
 rtl/bin2bcd_seq_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, digit width and the decimal range limit.
package bin2bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned bcd_max(input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
// Purely combinational; the carry out of the 4-bit sum is dropped.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  assign q = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Leading-zero blanking is built only when BIN2BCD_LZB_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int IN_W   = 20,
  parameter int DIGITS = 6
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_bin,
  output logic                    out_valid,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    ovf,
  output logic [DIGITS-1:0]       blank_mask
);

  localparam int OUT_W = BCD_W * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W-1:0] MAX_V = IN_W'(bcd_max(DIGITS));
  localparam logic [OUT_W-1:0] NINES = {DIGITS{4'h9}};

  state_e            state_q;
  state_e            state_d;
  logic [IN_W-1:0]   shift_q;
  logic [IN_W-1:0]   shift_nx;
  logic [OUT_W-1:0]  bcd_q;
  logic [OUT_W-1:0]  bcd_adj;
  logic [OUT_W-1:0]  bcd_nx;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_lat;
  logic              accept;
  logic              last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CNT_W'(IN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd_q[g*BCD_W +: BCD_W]),
      .q (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  // Corrected digits and the binary operand shift as one wide register.
  assign {bcd_nx, shift_nx} = {bcd_adj, shift_q} << 1;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_lat <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      shift_q <= in_bin;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_lat <= (in_bin > MAX_V);
    end else if (state_q == SHIFT) begin
      shift_q <= shift_nx;
      bcd_q   <= bcd_nx;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last) begin
        bcd_out <= ovf_lat ? NINES : bcd_nx;
        ovf     <= ovf_lat;
      end
    end
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_nx;
  logic [DIGITS-1:0] blank_q;

  // Walk down from the top digit; a digit blanks only under a zero prefix.
  always_comb begin
    logic z;
    z        = 1'b1;
    blank_nx = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z           = z & (bcd_nx[i*BCD_W +: BCD_W] == '0);
      blank_nx[i] = z;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= '0;
    end else if (state_q == SHIFT && last) begin
      blank_q <= ovf_lat ? '0 : blank_nx;
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
// Blank-mask expectations follow BIN2BCD_LZB_EN when it is defined.
module tb_bin2bcd_seq;

  logic        CLOCK_50;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_bin;
  logic        out_valid;
  logic [23:0] bcd_out;
  logic        ovf;
  logic [5:0]  blank_mask;

  int checks;
  int errors;

  bin2bcd_seq dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .bcd_out    (bcd_out),
    .ovf        (ovf),
    .blank_mask (blank_mask)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    if (v > 999999) return 24'h999999;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return v > 999999;
  endfunction

  function automatic logic [5:0] ref_blank(input int unsigned v);
    logic [5:0] m;
    m = '0;
`ifdef BIN2BCD_LZB_EN
    if (v <= 999999) begin
      for (int i = 1; i < 6; i++) begin
        if (v < 10 ** i) m[i] = 1'b1;
      end
    end
`endif
    return m;
  endfunction

  // Present a value, hold it until accepted; returns the acceptance time.
  task automatic send(input int unsigned v, output time t_acc);
    int n;
    in_valid = 1'b1;
    in_bin   = 20'(v);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    @(posedge CLOCK_50);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
  endtask

  // Count falling edges until out_valid shows up (bounded).
  task automatic wait_done(output int n, output int lo);
    n  = 0;
    lo = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
      if (!in_ready) lo++;
    end while (!out_valid && n < 100);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_bin   = '0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({in_ready, out_valid, ovf} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 100", {in_ready, out_valid, ovf});
    end
    checks++;
    if (bcd_out !== 24'h0 || blank_mask !== 6'h0) begin
      errors++;
      $display("FAIL reset_data: got bcd=%h blank=%b required 0", bcd_out, blank_mask);
    end
    reset_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_latency();
    time t;
    int n, lo;
    send(123456, t);
    wait_done(n, lo);
    checks++;
    if (n !== 21) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 21", n);
    end
    checks++;
    if (lo !== 21) begin
      errors++;
      $display("FAIL ready_low: got %0d cycles required 21", lo);
    end
    checks++;
    if (bcd_out !== 24'h123456 || ovf !== 1'b0 || blank_mask !== ref_blank(123456)) begin
      errors++;
      $display("FAIL basic_value: got %h/%b/%b required 123456/0/%b",
               bcd_out, ovf, blank_mask, ref_blank(123456));
    end
    @(negedge CLOCK_50);
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 24'h123456) begin
      errors++;
      $display("FAIL pulse_hold: got valid=%b bcd=%h required 0/123456", out_valid, bcd_out);
    end
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    int n, lo;
    send(0, t0);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== ref_bcd(0) || ovf !== 1'b0 || blank_mask !== ref_blank(0)) begin
      errors++;
      $display("FAIL zero_value: got %h/%b/%b required %h/0/%b",
               bcd_out, ovf, blank_mask, ref_bcd(0), ref_blank(0));
    end
    send(999999, t1);
    checks++;
    if ((t1 - t0) / 10 !== 22) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles required 22", (t1 - t0) / 10);
    end
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h999999 || ovf !== 1'b0 || blank_mask !== ref_blank(999999)) begin
      errors++;
      $display("FAIL max_value: got %h/%b/%b required 999999/0/%b",
               bcd_out, ovf, blank_mask, ref_blank(999999));
    end
  endtask

  task automatic test_overflow();
    time t;
    int n, lo;
    send(1000000, t);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h999999 || ovf !== 1'b1 || blank_mask !== 6'h0) begin
      errors++;
      $display("FAIL ovf_value: got %h/%b/%b required 999999/1/000000",
               bcd_out, ovf, blank_mask);
    end
    send(7, t);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h000007 || ovf !== 1'b0 || blank_mask !== ref_blank(7)) begin
      errors++;
      $display("FAIL ovf_clear: got %h/%b/%b required 000007/0/%b",
               bcd_out, ovf, blank_mask, ref_blank(7));
    end
  endtask

  task automatic test_busy_ignore();
    time t;
    int pulses;
    logic [23:0] seen;
    send(500000, t);
    repeat (4) @(negedge CLOCK_50);
    in_valid = 1'b1;
    in_bin   = 20'd42;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    pulses = 0;
    seen   = '0;
    repeat (40) begin
      @(negedge CLOCK_50);
      if (out_valid) begin
        pulses++;
        seen = bcd_out;
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL busy_pulses: got %0d required 1", pulses);
    end
    checks++;
    if (seen !== 24'h500000 || bcd_out !== 24'h500000) begin
      errors++;
      $display("FAIL busy_value: got %h/%h required 500000", seen, bcd_out);
    end
  endtask

  task automatic test_reset_mid();
    time t;
    int pulses, n, lo;
    send(654321, t);
    repeat (10) @(negedge CLOCK_50);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 24'h0 || ovf !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || blank_mask !== 6'h0) begin
      errors++;
      $display("FAIL mid_reset: got bcd=%h ovf=%b ov=%b rdy=%b bl=%b required 0/0/0/1/0",
               bcd_out, ovf, out_valid, in_ready, blank_mask);
    end
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge CLOCK_50);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort: got pulses=%0d rdy=%b required 0/1", pulses, in_ready);
    end
    send(11, t);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h000011 || ovf !== 1'b0 || blank_mask !== ref_blank(11)) begin
      errors++;
      $display("FAIL post_reset: got %h/%b/%b required 000011/0/%b",
               bcd_out, ovf, blank_mask, ref_blank(11));
    end
  endtask

  task automatic test_blank();
    time t;
    int n, lo;
    logic [5:0] exp42, exp0;
`ifdef BIN2BCD_LZB_EN
    exp42 = 6'b111100;
    exp0  = 6'b111110;
`else
    exp42 = 6'b000000;
    exp0  = 6'b000000;
`endif
    send(42, t);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h000042 || blank_mask !== exp42) begin
      errors++;
      $display("FAIL blank_42: got %h/%b required 000042/%b", bcd_out, blank_mask, exp42);
    end
    send(0, t);
    wait_done(n, lo);
    checks++;
    if (bcd_out !== 24'h0 || blank_mask !== exp0) begin
      errors++;
      $display("FAIL blank_0: got %h/%b required 000000/%b", bcd_out, blank_mask, exp0);
    end
  endtask

  task automatic test_random();
    time t;
    int n, lo;
    int unsigned v;
    for (int k = 0; k < 40; k++) begin
      v = (k % 4 == 0) ? $urandom_range(1048575, 990000) : $urandom_range(999999, 0);
      send(v, t);
      wait_done(n, lo);
      checks++;
      if (bcd_out !== ref_bcd(v) || ovf !== ref_ovf(v) || blank_mask !== ref_blank(v)) begin
        errors++;
        $display("FAIL rand_%0d: in=%0d got %h/%b/%b required %h/%b/%b", k, v,
                 bcd_out, ovf, blank_mask, ref_bcd(v), ref_ovf(v), ref_blank(v));
      end
      repeat ($urandom_range(2, 0)) @(negedge CLOCK_50);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_busy_ignore();
    test_reset_mid();
    test_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
